// File: rtl/delay_and_sum_div_21s_11ns_seq.sv
// delay_and_sum_div_21s_11ns_seq
//
// Sequential radix-2 restoring divider placed after the beam summation
// stage. It divides a signed summed-beam sample by an unsigned gain or
// normalisation word and returns a truncated (C-style) signed quotient
// and remainder. One quotient bit is resolved per clock, MSB first, and
// only one division is in flight at a time.
//
// Ports:
//   ap_clk       clock, rising edge
//   ap_rst_n     asynchronous active-low reset
//   din0         signed dividend   [DIVIDEND_WIDTH-1:0]
//   din1         unsigned divisor  [DIVISOR_WIDTH-1:0]
//   in_valid     operands valid
//   in_ready     block can accept operands (IDLE only)
//   quot         signed quotient   [DIVIDEND_WIDTH-1:0]
//   rem          signed remainder  [DIVISOR_WIDTH:0]
//   div_by_zero  result came from din1 == 0
//   dout_sat     quotient was clamped (constant 0 unless saturation built in)
//   out_valid    result valid, held until out_ready
//   out_ready    downstream accepts result
//
// Build option: define DELAY_AND_SUM_DIV_SAT_EN to clamp the quotient to
// the signed QSAT_WIDTH range in the DONE state.
module delay_and_sum_div_21s_11ns_seq #(
   parameter int DIVIDEND_WIDTH = 21,
   parameter int DIVISOR_WIDTH  = 11,
   parameter int QSAT_WIDTH     = 10
) (
   input  logic                      ap_clk,
   input  logic                      ap_rst_n,
   input  logic [DIVIDEND_WIDTH-1:0] din0,
   input  logic [DIVISOR_WIDTH-1:0]  din1,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [DIVIDEND_WIDTH-1:0] quot,
   output logic [DIVISOR_WIDTH:0]    rem,
   output logic                      div_by_zero,
   output logic                      dout_sat,
   output logic                      out_valid,
   input  logic                      out_ready
);

   localparam int N  = DIVIDEND_WIDTH;
   localparam int DW = DIVISOR_WIDTH;
   localparam int CW = $clog2(N);

   localparam logic [N-1:0] Q_MIN = {1'b1, {(N-1){1'b0}}};
   localparam logic [N-1:0] Q_MAX = {1'b0, {(N-1){1'b1}}};

   // The saturation range must fit inside the quotient word.
   if (QSAT_WIDTH < 2 || QSAT_WIDTH > DIVIDEND_WIDTH) begin : g_bad_qsat
      $error("QSAT_WIDTH must lie in [2, DIVIDEND_WIDTH]");
   end

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t         state;
   state_t         state_next;

   logic           sign_q;
   logic           sign_r;
   logic           dz;
   logic [DW-1:0]  divisor;
   // Holds |dividend| at start; quotient bits shift in from the LSB as
   // dividend bits leave from the MSB, so it ends up holding |quotient|.
   logic [N-1:0]   acc;
   logic [DW-1:0]  prem;
   logic [CW-1:0]  cnt;

   logic [DW:0]    rem_sh;
   logic           ge;
   logic [DW-1:0]  sub_lo;
   logic [N-1:0]   acc_neg;
   logic [N-1:0]   q_full;
   logic [DW:0]    r_full;
   logic [N-1:0]   q_res;
   logic           sat;

   assign in_ready = (state == IDLE);

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (in_valid) begin
               state_next = (din1 == '0) ? DONE : CALC;
            end
         end
         CALC: begin
            if (cnt == '0) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (out_valid && out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ------------------------------------------------------------------
   // Iteration and sign-application datapath
   // ------------------------------------------------------------------
   always_comb begin
      rem_sh  = {prem, acc[N-1]};
      ge      = (rem_sh >= {1'b0, divisor});
      // When ge holds the difference is below the divisor, so the low
      // DW bits carry the full result.
      sub_lo  = rem_sh[DW-1:0] - divisor;
      acc_neg = -acc;

      if (dz) begin
         q_full = sign_q ? Q_MIN : Q_MAX;
         // -|din0| equals din0, so its low bits are the original ones.
         r_full = {sign_r, (sign_r ? acc_neg[DW-1:0] : acc[DW-1:0])};
      end else begin
         q_full = sign_q ? acc_neg : acc;
         r_full = sign_r ? -{1'b0, prem} : {1'b0, prem};
      end
   end

`ifdef DELAY_AND_SUM_DIV_SAT_EN
   localparam logic signed [N-1:0] SAT_HI = N'((1 <<< (QSAT_WIDTH-1)) - 1);
   localparam logic signed [N-1:0] SAT_LO = N'(-(1 <<< (QSAT_WIDTH-1)));

   always_comb begin
      q_res = q_full;
      sat   = 1'b0;
      if ($signed(q_full) > SAT_HI) begin
         q_res = SAT_HI;
         sat   = 1'b1;
      end else if ($signed(q_full) < SAT_LO) begin
         q_res = SAT_LO;
         sat   = 1'b1;
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         dout_sat <= 1'b0;
      end else if (state == DONE && !out_valid) begin
         dout_sat <= sat;
      end
   end
`else
   assign q_res    = q_full;
   assign sat      = 1'b0;
   assign dout_sat = sat;
`endif

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         sign_q      <= 1'b0;
         sign_r      <= 1'b0;
         dz          <= 1'b0;
         divisor     <= '0;
         acc         <= '0;
         prem        <= '0;
         cnt         <= '0;
         quot        <= '0;
         rem         <= '0;
         div_by_zero <= 1'b0;
         out_valid   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sign_q  <= din0[N-1];
                  sign_r  <= din0[N-1];
                  // -2^(N-1) negates to itself, which read unsigned is
                  // exactly the required magnitude 2^(N-1).
                  acc     <= din0[N-1] ? -din0 : din0;
                  divisor <= din1;
                  dz      <= (din1 == '0);
                  prem    <= '0;
                  cnt     <= CW'(N-1);
               end
            end
            CALC: begin
               acc  <= {acc[N-2:0], ge};
               prem <= ge ? sub_lo : rem_sh[DW-1:0];
               cnt  <= cnt - 1'b1;
            end
            DONE: begin
               // First DONE cycle registers the signed result; the
               // following cycles hold it until the downstream takes it.
               if (!out_valid) begin
                  quot        <= q_res;
                  rem         <= r_full;
                  div_by_zero <= dz;
                  out_valid   <= 1'b1;
               end else if (out_ready) begin
                  out_valid   <= 1'b0;
               end
            end
            default: begin
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_delay_and_sum_div_21s_11ns_seq.sv
module tb_delay_and_sum_div_21s_11ns_seq;

   localparam int N  = 21;
   localparam int DW = 11;
   localparam int QS = 10;

   logic                ap_clk;
   logic                ap_rst_n;
   logic signed [N-1:0] din0;
   logic [DW-1:0]       din1;
   logic                in_valid;
   logic                in_ready;
   logic [N-1:0]        quot;
   logic [DW:0]         rem;
   logic                div_by_zero;
   logic                dout_sat;
   logic                out_valid;
   logic                out_ready;

   int n_assert;
   int n_fail;

   delay_and_sum_div_21s_11ns_seq #(
      .DIVIDEND_WIDTH(N),
      .DIVISOR_WIDTH (DW),
      .QSAT_WIDTH    (QS)
   ) dut (
      .ap_clk     (ap_clk),
      .ap_rst_n   (ap_rst_n),
      .din0       (din0),
      .din1       (din1),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .quot       (quot),
      .rem        (rem),
      .div_by_zero(div_by_zero),
      .dout_sat   (dout_sat),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
   );

   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: C truncating division on plain integers, with the
   // zero-divisor and optional clamping rules applied afterwards.
   task automatic model(input logic signed [N-1:0] a, input logic [DW-1:0] b,
                        output logic [N-1:0] q, output logic [DW:0] r,
                        output logic dz, output logic sat);
      longint la, lb, lq, lr;
      la  = a;
      lb  = longint'(b);
      sat = 1'b0;
      if (lb == 0) begin
         dz = 1'b1;
         lq = (la < 0) ? -(longint'(1) << (N-1)) : (longint'(1) << (N-1)) - 1;
         r  = {a[N-1], a[DW-1:0]};
      end else begin
         dz = 1'b0;
         lq = la / lb;
         lr = la % lb;
         r  = lr[DW:0];
      end
`ifdef DELAY_AND_SUM_DIV_SAT_EN
      if (lq > (longint'(1) << (QS-1)) - 1) begin
         lq  = (longint'(1) << (QS-1)) - 1;
         sat = 1'b1;
      end else if (lq < -(longint'(1) << (QS-1))) begin
         lq  = -(longint'(1) << (QS-1));
         sat = 1'b1;
      end
`endif
      q = lq[N-1:0];
   endtask

   task automatic do_op(input logic signed [N-1:0] a, input logic [DW-1:0] b, input int hold);
      logic [N-1:0] eq;
      logic [DW:0]  er;
      logic         edz, esat;
      int           cycles;
      int           lat;
      model(a, b, eq, er, edz, esat);
      lat = (b == '0) ? 1 : N + 1;
      @(negedge ap_clk);
      din0      = a;
      din1      = b;
      in_valid  = 1'b1;
      out_ready = (hold == 0);
      chk("in_ready_idle", 64'(in_ready), 64'(1'b1));
      @(posedge ap_clk);
      #1;
      in_valid = 1'b0;
      din0     = N'($urandom);
      din1     = DW'($urandom);
      chk("in_ready_busy", 64'(in_ready), 64'(1'b0));
      cycles = 0;
      while (!out_valid && cycles < 100) begin
         @(posedge ap_clk);
         #1;
         cycles++;
      end
      chk("latency", 64'(cycles), 64'(lat));
      chk("quot", 64'(quot), 64'(eq));
      chk("rem", 64'(rem), 64'(er));
      chk("div_by_zero", 64'(div_by_zero), 64'(edz));
      chk("dout_sat", 64'(dout_sat), 64'(esat));
      for (int i = 0; i < hold; i++) begin
         @(posedge ap_clk);
         #1;
         chk("hold_valid", 64'(out_valid), 64'(1'b1));
         chk("hold_quot", 64'(quot), 64'(eq));
         chk("hold_rem", 64'(rem), 64'(er));
         chk("hold_in_ready", 64'(in_ready), 64'(1'b0));
      end
      out_ready = 1'b1;
      @(posedge ap_clk);
      #1;
      chk("valid_drop", 64'(out_valid), 64'(1'b0));
      chk("back_idle", 64'(in_ready), 64'(1'b1));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic seen;
      logic signed [N-1:0] ra;
      logic [DW-1:0]       rb;
      n_assert  = 0;
      n_fail    = 0;
      ap_rst_n  = 1'b0;
      din0      = '0;
      din1      = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(posedge ap_clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'(1'b0));
      chk("rst_quot", 64'(quot), 64'(0));
      chk("rst_rem", 64'(rem), 64'(0));
      chk("rst_dz", 64'(div_by_zero), 64'(1'b0));
      chk("rst_sat", 64'(dout_sat), 64'(1'b0));
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'(1'b1));

      do_op(21'sd1000, 11'd7, 0);
      do_op(-21'sd1000, 11'd7, 0);
      do_op(-21'sd1048576, 11'd1, 0);
      do_op(21'sd1048575, 11'd1, 0);
      do_op(-21'sd5, 11'd0, 0);
      do_op(21'sd1000, 11'd0, 1);
      do_op(21'sd2047, 11'd2047, 10);
      do_op(-21'sd1048576, 11'd2047, 2);
      do_op(21'sd3, 11'd2047, 0);
      do_op(21'sd100000, 11'd3, 0);
      do_op(-21'sd100000, 11'd3, 0);

      // Reset in the middle of an iteration: nothing may surface later.
      @(negedge ap_clk);
      din0      = 21'sd1000;
      din1      = 11'd7;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge ap_clk);
      #1;
      in_valid = 1'b0;
      repeat (8) @(posedge ap_clk);
      #1;
      ap_rst_n = 1'b0;
      #1;
      chk("abort_valid", 64'(out_valid), 64'(1'b0));
      chk("abort_quot", 64'(quot), 64'(0));
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      seen = 1'b0;
      repeat (30) begin
         @(posedge ap_clk);
         #1;
         seen = seen | out_valid;
      end
      chk("no_stale_result", 64'(seen), 64'(1'b0));
      do_op(21'sd21, 11'd4, 0);

      for (int i = 0; i < 24; i++) begin
         ra = N'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom);
         if (i == 3) ra = -21'sd1048576;
         if (i == 5) rb = 11'd1;
         do_op(ra, rb, int'($urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
